// File: rtl/board_mem_arbiter.sv
// rtl/board_mem_arbiter.sv - snake board memory arbiter and game-step scheduler
//
// Shares the single-port board memory between the pixel renderer (absolute
// priority, never stalled) and the game logic (granted only in blanking while
// an update window is open). Every FRAMES_PER_STEP frames a one-cycle step
// pulse opens a game window; step_done closes it. A window still open when
// active video resumes is suspended until the next vblank_start.
//
// Ports:
//   clk, reset           pixel clock, synchronous active-high reset
//   vblank_start         one-cycle pulse at the first blanked line
//   display_active       beam in visible region
//   rd_req/rd_addr       renderer read request; rd_data/rd_valid response
//   g_req/g_we/g_addr/g_wdata   game access; g_ready grant
//   g_rdata/g_rvalid     game read response
//   step/step_done       game update start pulse / completion pulse
//   mem_*                single-port memory, 1-cycle read latency
//   overrun              sticky: an update spilled past blanking
module board_mem_arbiter #(
    parameter int ADDR_W          = 10,
    parameter int DATA_W          = 2,
    parameter int FRAMES_PER_STEP = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vblank_start,
    input  logic              display_active,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              g_req,
    input  logic              g_we,
    input  logic [ADDR_W-1:0] g_addr,
    input  logic [DATA_W-1:0] g_wdata,
    output logic              g_ready,
    output logic [DATA_W-1:0] g_rdata,
    output logic              g_rvalid,
    output logic              step,
    input  logic              step_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              overrun
);

    localparam logic [7:0] STEP_FRAMES = 8'(FRAMES_PER_STEP);

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_STEP    = 2'd1,
        S_GAME    = 2'd2,
        S_SUSPEND = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] frame_cnt;
    logic       g_xfer;

    // Scheduler FSM. vblank_start is only counted in WAIT; in SUSPEND it
    // resumes the window without advancing the frame count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_WAIT;
            frame_cnt <= 8'd0;
            step      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            step <= 1'b0;
            case (state)
                S_WAIT: begin
                    if (vblank_start) begin
                        if (frame_cnt + 8'd1 == STEP_FRAMES) begin
                            frame_cnt <= 8'd0;
                            state     <= S_STEP;
                            step      <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                S_STEP: begin
                    state <= S_GAME;
                end
                S_GAME: begin
                    // step_done beats a simultaneous rise of display_active
                    if (step_done) begin
                        state <= S_WAIT;
                    end else if (display_active) begin
                        overrun <= 1'b1;
                        state   <= S_SUSPEND;
                    end
                end
                S_SUSPEND: begin
                    if (step_done) begin
                        state <= S_WAIT;
                    end else if (vblank_start) begin
                        state <= S_GAME;
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

    // Grant drops in the same cycle the renderer asks or video resumes.
    assign g_ready = (state == S_GAME) & ~rd_req & ~display_active;
    assign g_xfer  = g_req & g_ready;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = g_addr;
        mem_wdata = g_wdata;
        if (rd_req) begin
            mem_en   = 1'b1;
            mem_addr = rd_addr;
        end else if (g_xfer) begin
            mem_en = 1'b1;
            mem_we = g_we;
        end
    end

    assign rd_data = mem_rdata;
    assign g_rdata = mem_rdata;

    // g_xfer already excludes rd_req, so the two valids are exclusive.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            g_rvalid <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            g_rvalid <= g_xfer & ~g_we;
        end
    end

endmodule

// File: tb/tb_board_mem_arbiter.sv
// tb/tb_board_mem_arbiter.sv - directed testbench for board_mem_arbiter
module tb_board_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       vblank_start;
    logic       display_active;
    logic       rd_req;
    logic [9:0] rd_addr;
    logic [1:0] rd_data;
    logic       rd_valid;
    logic       g_req;
    logic       g_we;
    logic [9:0] g_addr;
    logic [1:0] g_wdata;
    logic       g_ready;
    logic [1:0] g_rdata;
    logic       g_rvalid;
    logic       step;
    logic       step_done;
    logic       mem_en;
    logic       mem_we;
    logic [9:0] mem_addr;
    logic [1:0] mem_wdata;
    logic [1:0] mem_rdata;
    logic       overrun;

    int n_vec = 0;
    int n_err = 0;
    int step_count;

    logic [1:0] mem [0:1023];

    board_mem_arbiter #(.ADDR_W(10), .DATA_W(2), .FRAMES_PER_STEP(3)) dut (
        .clk(clk), .reset(reset), .vblank_start(vblank_start),
        .display_active(display_active), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .g_req(g_req), .g_we(g_we),
        .g_addr(g_addr), .g_wdata(g_wdata), .g_ready(g_ready),
        .g_rdata(g_rdata), .g_rvalid(g_rvalid), .step(step),
        .step_done(step_done), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .overrun(overrun)
    );

    always #20 clk = ~clk;

    // Board memory: cell i preloads to i[1:0]; 0x0AA->2, 0x055->1, 0x155->1.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= i[1:0];
            mem_rdata <= 2'b00;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    always @(posedge clk) begin
        if (reset) step_count <= 0;
        else if (step) step_count <= step_count + 1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        vblank_start = 0; display_active = 0; rd_req = 0; rd_addr = 0;
        g_req = 0; g_we = 0; g_addr = 0; g_wdata = 0; step_done = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        cyc();
        cyc();
        reset = 0;
    endtask

    task automatic pulse_vblank();
        vblank_start = 1;
        cyc();
        vblank_start = 0;
    endtask

    // Leaves the DUT in GAME with all inputs idle.
    task automatic enter_game();
        do_reset();
        repeat (3) pulse_vblank();
        cyc();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_vec++; if (step !== 1'b0) begin n_err++; $display("FAIL reset_step: got %0h expected 0", step); end
        n_vec++; if (g_ready !== 1'b0) begin n_err++; $display("FAIL reset_g_ready: got %0h expected 0", g_ready); end
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %0h expected 0", rd_valid); end
        n_vec++; if (g_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_g_rvalid: got %0h expected 0", g_rvalid); end
        n_vec++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_en_we: got %0h%0h expected 00", mem_en, mem_we); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %0h expected 0", overrun); end
    endtask

    task automatic test_frame_sched();
        logic exp_step;
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            pulse_vblank();
            exp_step = (i == 3 || i == 6);
            n_vec++; if (step !== exp_step) begin n_err++; $display("FAIL sched_step_v%0d: got %0h expected %0h", i, step, exp_step); end
            if (exp_step) begin
                cyc();
                n_vec++; if (step !== 1'b0) begin n_err++; $display("FAIL sched_step_width_v%0d: got %0h expected 0", i, step); end
                repeat (9) cyc();
                step_done = 1;
                cyc();
                step_done = 0;
            end else begin
                repeat (2) cyc();
            end
        end
        n_vec++; if (step_count !== 2) begin n_err++; $display("FAIL sched_step_count: got %0d expected 2", step_count); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL sched_overrun: got %0h expected 0", overrun); end
    endtask

    task automatic test_priority();
        enter_game();
        rd_req = 1; rd_addr = 10'h0AA;
        g_req = 1; g_we = 0; g_addr = 10'h055;
        for (int c = 1; c <= 4; c++) begin
            #1;
            n_vec++; if (g_ready !== 1'b0) begin n_err++; $display("FAIL prio_g_ready_c%0d: got %0h expected 0", c, g_ready); end
            n_vec++; if (mem_addr !== 10'h0AA || mem_en !== 1'b1 || mem_we !== 1'b0) begin n_err++; $display("FAIL prio_mem_c%0d: got addr %0h en %0h we %0h expected addr aa en 1 we 0", c, mem_addr, mem_en, mem_we); end
            n_vec++; if (rd_valid !== (c > 1)) begin n_err++; $display("FAIL prio_rd_valid_c%0d: got %0h expected %0h", c, rd_valid, (c > 1)); end
            if (c == 2) begin
                n_vec++; if (rd_data !== 2'b10) begin n_err++; $display("FAIL prio_rd_data: got %0h expected 2", rd_data); end
            end
            cyc();
        end
        rd_req = 0;
        #1;
        n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL prio_rd_valid_c5: got %0h expected 1", rd_valid); end
        n_vec++; if (g_ready !== 1'b1 || mem_addr !== 10'h055 || mem_en !== 1'b1) begin n_err++; $display("FAIL prio_game_accept: got ready %0h addr %0h en %0h expected 1 55 1", g_ready, mem_addr, mem_en); end
        cyc();
        g_req = 0;
        #1;
        n_vec++; if (g_rvalid !== 1'b1 || g_rdata !== 2'b01) begin n_err++; $display("FAIL prio_g_read: got rvalid %0h data %0h expected 1 1", g_rvalid, g_rdata); end
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL prio_rd_valid_c6: got %0h expected 0", rd_valid); end
    endtask

    task automatic test_game_rw();
        enter_game();
        g_req = 1; g_we = 1; g_addr = 10'h155; g_wdata = 2'b11;
        #1;
        n_vec++; if (g_ready !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 2'b11) begin n_err++; $display("FAIL rw_write_issue: got ready %0h we %0h wdata %0h expected 1 1 3", g_ready, mem_we, mem_wdata); end
        cyc();
        g_req = 0; g_we = 0;
        #1;
        n_vec++; if (g_rvalid !== 1'b0) begin n_err++; $display("FAIL rw_no_rvalid_after_write: got %0h expected 0", g_rvalid); end
        // vblank inside the window is neither counted nor a state change
        pulse_vblank();
        n_vec++; if (step !== 1'b0 || g_ready !== 1'b1) begin n_err++; $display("FAIL rw_vblank_in_game: got step %0h ready %0h expected 0 1", step, g_ready); end
        // read the written cell in the same cycle step_done arrives
        g_req = 1; g_we = 0; g_addr = 10'h155; step_done = 1;
        cyc();
        g_req = 0; step_done = 0;
        #1;
        n_vec++; if (g_rvalid !== 1'b1 || g_rdata !== 2'b11) begin n_err++; $display("FAIL rw_read_back: got rvalid %0h data %0h expected 1 3", g_rvalid, g_rdata); end
        n_vec++; if (g_ready !== 1'b0) begin n_err++; $display("FAIL rw_wait_after_done: got %0h expected 0", g_ready); end
        cyc();
        n_vec++; if (g_rvalid !== 1'b0) begin n_err++; $display("FAIL rw_rvalid_width: got %0h expected 0", g_rvalid); end
    endtask

    task automatic test_overrun();
        enter_game();
        display_active = 1;
        #1;
        n_vec++; if (g_ready !== 1'b0) begin n_err++; $display("FAIL ovr_ready_on_active: got %0h expected 0", g_ready); end
        cyc();
        display_active = 0; g_req = 1; g_addr = 10'h055;
        #1;
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %0h expected 1", overrun); end
        n_vec++; if (g_ready !== 1'b0 || mem_en !== 1'b0) begin n_err++; $display("FAIL ovr_suspended: got ready %0h en %0h expected 0 0", g_ready, mem_en); end
        g_req = 0;
        repeat (2) cyc();
        pulse_vblank();
        #1;
        n_vec++; if (g_ready !== 1'b1 || step !== 1'b0) begin n_err++; $display("FAIL ovr_resume: got ready %0h step %0h expected 1 0", g_ready, step); end
        step_done = 1;
        cyc();
        step_done = 0;
        #1;
        n_vec++; if (g_ready !== 1'b0 || overrun !== 1'b1) begin n_err++; $display("FAIL ovr_done_to_wait: got ready %0h overrun %0h expected 0 1", g_ready, overrun); end
        // the resume vblank must not have advanced the frame count
        for (int i = 1; i <= 3; i++) begin
            pulse_vblank();
            n_vec++; if (step !== (i == 3)) begin n_err++; $display("FAIL ovr_next_step_v%0d: got %0h expected %0h", i, step, (i == 3)); end
        end
    endtask

    task automatic test_simultaneous();
        enter_game();
        step_done = 1; display_active = 1;
        cyc();
        step_done = 0; display_active = 0;
        #1;
        n_vec++; if (overrun !== 1'b0 || g_ready !== 1'b0) begin n_err++; $display("FAIL simul_done_wins: got overrun %0h ready %0h expected 0 0", overrun, g_ready); end
        // in WAIT a vblank only counts; from SUSPEND it would reopen the grant
        pulse_vblank();
        #1;
        n_vec++; if (g_ready !== 1'b0 || step !== 1'b0) begin n_err++; $display("FAIL simul_in_wait: got ready %0h step %0h expected 0 0", g_ready, step); end
    endtask

    task automatic test_reset_mid();
        enter_game();
        g_req = 1; g_we = 0; g_addr = 10'h055;
        #1;
        n_vec++; if (g_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready_before: got %0h expected 1", g_ready); end
        reset = 1;
        cyc();
        reset = 0; g_req = 0;
        #1;
        n_vec++; if (g_rvalid !== 1'b0 || step !== 1'b0 || g_ready !== 1'b0 || overrun !== 1'b0) begin n_err++; $display("FAIL rstmid_state: got rvalid %0h step %0h ready %0h overrun %0h expected 0 0 0 0", g_rvalid, step, g_ready, overrun); end
        for (int i = 1; i <= 3; i++) begin
            pulse_vblank();
            n_vec++; if (step !== (i == 3)) begin n_err++; $display("FAIL rstmid_step_v%0d: got %0h expected %0h", i, step, (i == 3)); end
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        test_reset();
        test_frame_sched();
        test_priority();
        test_game_rw();
        test_overrun();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
